pong_sfx_player: RTL and testbench

//  Parametrised successor to the single-tone sound unit: NUM_CH sound-effect channels (e.g. paddle hit, wall, score).

---
 rtl/pong_sfx_player_if.sv | 30 +++
 rtl/pong_sfx_player.sv | 163 ++++++++++++++++
 tb/tb_pong_sfx_player.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pong_sfx_player_if.sv
// Signal bundle between the game top and the multi-channel sound-effect player.
// The game side drives triggers and tone settings; the player returns audio and status.
interface pong_sfx_player_if #(
    parameter int NUM_CH = 3,
    parameter int DIV_W  = 18,
    parameter int DUR_W  = 24,
    parameter int PWM_W  = 8
) ();
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]       trig;
    logic [NUM_CH*DIV_W-1:0] half_per;
    logic [NUM_CH*DUR_W-1:0] duration;
    logic [PWM_W-1:0]        volume;
    logic                    mute;
    logic                    AUD_PWM;
    logic                    AUD_SD;
    logic                    busy;
    logic [CH_W-1:0]         active_ch;

    modport master (
        output trig, half_per, duration, volume, mute,
        input  AUD_PWM, AUD_SD, busy, active_ch
    );

    modport slave (
        input  trig, half_per, duration, volume, mute,
        output AUD_PWM, AUD_SD, busy, active_ch
    );
endinterface

// File: rtl/pong_sfx_player.sv
// Multi-channel square-wave sound-effect player: edge-triggered requests, fixed
// priority with preemption, a silent gap between effects, and a volume PWM.
module pong_sfx_player #(
    parameter int NUM_CH  = 3,
    parameter int DIV_W   = 18,
    parameter int DUR_W   = 24,
    parameter int PWM_W   = 8,
    parameter int GAP_CYC = 1000
) (
    input logic              clk,
    input logic              rst,
    pong_sfx_player_if.slave sfx
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PLAY = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0]        state;
    logic [NUM_CH-1:0] trig_q;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] set_mask;
    logic [NUM_CH-1:0] clr_mask;
    logic [NUM_CH-1:0] hp_onehot;
    logic [NUM_CH-1:0] act_mask;
    logic [CH_W-1:0]   hp;
    logic [CH_W-1:0]   active_ch;
    logic [CH_W-1:0]   sel_ch;
    logic [DUR_W-1:0]  dur_cnt;
    logic [DUR_W-1:0]  dur_sel;
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  cur_half;
    logic [DIV_W-1:0]  half_sel;
    logic [GAP_W-1:0]  gap_cnt;
    logic [PWM_W-1:0]  pwm_cnt;
    logic              tone;
    logic              act_rise;
    logic              any_pend;
    logic              load;
    logic              retrig;
    logic              aud_pwm;
    logic              aud_sd;

    assign rise     = sfx.trig & ~trig_q;
    assign any_pend = |pending;

    always_comb begin
        hp        = '0;
        hp_onehot = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (pending[i]) begin
                hp           = CH_W'(i);
                hp_onehot    = '0;
                hp_onehot[i] = 1'b1;
            end
        end
    end

    // Preemption outranks a retrigger of the channel being displaced.
    always_comb begin
        load   = 1'b0;
        retrig = 1'b0;
        case (state)
            IDLE: load = any_pend;
            PLAY: begin
                if (any_pend && (hp > active_ch)) load = 1'b1;
                else if (act_rise)                retrig = 1'b1;
            end
            GAP:     load = any_pend && (gap_cnt == GAP_W'(1));
            default: ;
        endcase
    end

    assign sel_ch = load ? hp : active_ch;

    always_comb begin
        dur_sel  = '0;
        half_sel = '0;
        act_rise = 1'b0;
        act_mask = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (CH_W'(i) == sel_ch) begin
                dur_sel  = sfx.duration[i*DUR_W +: DUR_W];
                half_sel = sfx.half_per[i*DIV_W +: DIV_W];
            end
            if (CH_W'(i) == active_ch) begin
                act_rise    = rise[i];
                act_mask[i] = 1'b1;
            end
        end
    end

    // Edges on the playing channel restart it instead of queuing a request.
    assign set_mask = rise & ~((state == PLAY) ? act_mask : '0);
    assign clr_mask = load ? hp_onehot : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            trig_q    <= '0;
            pending   <= '0;
            active_ch <= '0;
            dur_cnt   <= '0;
            div_cnt   <= '0;
            cur_half  <= '0;
            gap_cnt   <= '0;
            pwm_cnt   <= '0;
            tone      <= 1'b0;
            aud_pwm   <= 1'b0;
            aud_sd    <= 1'b0;
        end else begin
            trig_q  <= sfx.trig;
            pending <= (pending | set_mask) & ~clr_mask;
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            aud_pwm <= tone & (pwm_cnt < sfx.volume) & ~sfx.mute & (state == PLAY);
            aud_sd  <= (state != IDLE);

            if (load || retrig) begin
                state     <= PLAY;
                active_ch <= sel_ch;
                dur_cnt   <= dur_sel;
                cur_half  <= half_sel;
                div_cnt   <= '0;
                tone      <= 1'b0;
            end else begin
                case (state)
                    PLAY: begin
                        if (dur_cnt <= DUR_W'(1)) begin
                            state   <= GAP;
                            gap_cnt <= GAP_W'(GAP_CYC);
                            tone    <= 1'b0;
                        end else begin
                            dur_cnt <= dur_cnt - DUR_W'(1);
                            if (cur_half == '0) begin
                                tone    <= 1'b0;
                                div_cnt <= '0;
                            end else if (div_cnt == cur_half - DIV_W'(1)) begin
                                div_cnt <= '0;
                                tone    <= ~tone;
                            end else begin
                                div_cnt <= div_cnt + DIV_W'(1);
                            end
                        end
                    end
                    GAP: begin
                        tone <= 1'b0;
                        if (gap_cnt == GAP_W'(1)) state <= IDLE;
                        else                      gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sfx.AUD_PWM   = aud_pwm;
    assign sfx.AUD_SD    = aud_sd;
    assign sfx.busy      = (state != IDLE);
    assign sfx.active_ch = active_ch;
endmodule

// File: tb/tb_pong_sfx_player.sv
module tb_pong_sfx_player;
  localparam int NUM_CH  = 3;
  localparam int DIV_W   = 18;
  localparam int DUR_W   = 24;
  localparam int PWM_W   = 8;
  localparam int GAP_CYC = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pong_sfx_player_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DUR_W(DUR_W), .PWM_W(PWM_W)) sfx ();

  pong_sfx_player #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DUR_W(DUR_W), .PWM_W(PWM_W), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sfx(sfx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       busy;
    logic [1:0] ch;
    logic       aud;
    logic       sd;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests  = 0;
  int   failed = 0;
  int   cyc    = 0;

  logic [2:0] trig_n = '0;
  int         half_n[3] = '{2, 4, 8};
  int         dur_n[3]  = '{10, 20, 40};
  int         vol_n     = 255;
  bit         mute_n    = 1'b0;
  logic [2:0] trig_a = '0;
  int         half_a[3] = '{2, 4, 8};
  int         dur_a[3]  = '{10, 20, 40};
  int         vol_a     = 255;
  bit         mute_a    = 1'b0;

  int       m_mode, m_ch, m_age, m_len, m_half, m_gap, m_pwm;
  bit [2:0] m_pend, m_prev;
  bit       m_aud, m_sd;

  function automatic bit tone_at(int age, int half);
    if (half == 0) return 1'b0;
    return ((age / half) % 2) == 1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_ch = 0; m_age = 0; m_len = 0; m_half = 0; m_gap = 0; m_pwm = 0;
    m_pend = '0; m_prev = '0; m_aud = 1'b0; m_sd = 1'b0;
  endtask

  task automatic start_effect(int c);
    m_mode = 1;
    m_ch   = c;
    m_age  = 0;
    m_len  = (dur_a[c] < 1) ? 1 : dur_a[c];
    m_half = half_a[c];
  endtask

  task automatic model_step();
    bit [2:0] rise;
    int       hp;
    int       ld;
    bit       rt;
    bit       nxt_aud;
    bit       nxt_sd;
    nxt_aud = (m_mode == 1) && tone_at(m_age, m_half) && (m_pwm < vol_a) && !mute_a;
    nxt_sd  = (m_mode != 0);
    rise    = trig_a & ~m_prev;
    hp      = -1;
    for (int i = 0; i < 3; i++) if (m_pend[i]) hp = i;
    ld = -1;
    rt = 1'b0;
    if (m_mode == 0 && hp >= 0) ld = hp;
    else if (m_mode == 1) begin
      if (hp > m_ch) ld = hp;
      else if (rise[m_ch]) rt = 1'b1;
    end else if (m_mode == 2 && m_gap == 1 && hp >= 0) ld = hp;
    if (m_mode == 1) rise[m_ch] = 1'b0;
    m_pend = m_pend | rise;
    if (ld >= 0) m_pend[ld] = 1'b0;

    if (ld >= 0) start_effect(ld);
    else if (rt) start_effect(m_ch);
    else if (m_mode == 1) begin
      if (m_age + 1 >= m_len) begin
        m_mode = 2;
        m_gap  = GAP_CYC;
      end else m_age++;
    end else if (m_mode == 2) begin
      if (m_gap == 1) m_mode = 0;
      else m_gap--;
    end
    m_prev = trig_a;
    m_pwm  = (m_pwm + 1) % 256;
    m_aud  = nxt_aud;
    m_sd   = nxt_sd;
  endtask

  task automatic apply();
    trig_a = trig_n;
    vol_a  = vol_n;
    mute_a = mute_n;
    sfx.trig   = trig_n;
    sfx.volume = PWM_W'(vol_n);
    sfx.mute   = mute_n;
    for (int i = 0; i < 3; i++) begin
      half_a[i] = half_n[i];
      dur_a[i]  = dur_n[i];
      sfx.half_per[i*DIV_W +: DIV_W] = DIV_W'(half_n[i]);
      sfx.duration[i*DUR_W +: DUR_W] = DUR_W'(dur_n[i]);
    end
  endtask

  task automatic tick(input logic [2:0] t, input bit r);
    exp_t e;
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else model_step();
    if (r) model_reset();
    e.busy = (m_mode != 0);
    e.ch   = 2'(m_ch);
    e.aud  = m_aud;
    e.sd   = m_sd;
    e.cyc  = cyc;
    exp_q.push_back(e);
    #1;
    trig_n = t;
    apply();
    #1;
    rst = r;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(3'b000, 1'b0);
  endtask

  task automatic check_reset_state();
    #1;
    tests++;
    if (sfx.busy !== 1'b0 || sfx.AUD_PWM !== 1'b0 || sfx.AUD_SD !== 1'b0 ||
        sfx.active_ch !== 2'd0) begin
      failed++;
      $display("FAIL reset state cyc=%0d busy=%b pwm=%b sd=%b ch=%0d",
               cyc, sfx.busy, sfx.AUD_PWM, sfx.AUD_SD, sfx.active_ch);
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (sfx.busy !== 1'b0 && n < max_cyc) begin
      tick(3'b000, 1'b0);
      n++;
    end
    tests++;
    if (sfx.busy !== 1'b0) begin
      failed++;
      $display("FAIL wait for idle expired after %0d cycles at cyc=%0d", max_cyc, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      tests++;
      if (sfx.busy !== mon_e.busy || sfx.active_ch !== mon_e.ch ||
          sfx.AUD_PWM !== mon_e.aud || sfx.AUD_SD !== mon_e.sd) begin
        failed++;
        $display("FAIL outputs cyc=%0d got busy=%b ch=%0d pwm=%b sd=%b want busy=%b ch=%0d pwm=%b sd=%b",
                 mon_e.cyc, sfx.busy, sfx.active_ch, sfx.AUD_PWM, sfx.AUD_SD,
                 mon_e.busy, mon_e.ch, mon_e.aud, mon_e.sd);
      end
    end
  end

  initial begin
    model_reset();
    apply();
    repeat (3) tick(3'b000, 1'b1);
    check_reset_state();
    tick(3'b000, 1'b0);

    tick(3'b010, 1'b0); idle(40);
    wait_idle(50);
    tick(3'b111, 1'b0); idle(100);
    wait_idle(120);
    tick(3'b001, 1'b0); idle(5);
    tick(3'b100, 1'b0); idle(70);
    tick(3'b010, 1'b0); idle(14);
    tick(3'b010, 1'b0); idle(50);
    wait_idle(60);

    half_n[0] = 0; tick(3'b001, 1'b0); idle(25);
    half_n[0] = 2; dur_n[0] = 0; tick(3'b001, 1'b0); idle(15);
    dur_n[0] = 10; vol_n = 0; tick(3'b010, 1'b0); idle(35);
    vol_n = 255; mute_n = 1'b1; tick(3'b010, 1'b0); idle(35);
    mute_n = 1'b0;

    tick(3'b010, 1'b0); idle(3);
    tick(3'b001, 1'b0); idle(3);
    repeat (3) tick(3'b000, 1'b1);
    check_reset_state();
    tick(3'b000, 1'b0); idle(30);
    tick(3'b001, 1'b1); tick(3'b001, 1'b0);
    repeat (8) tick(3'b001, 1'b0);
    idle(30);

    for (int n = 0; n < 4000; n++) begin
      logic [2:0] t;
      int         c;
      t = trig_n;
      for (int k = 0; k < 3; k++) if ($urandom_range(0, 11) == 0) t[k] = ~t[k];
      if ($urandom_range(0, 39) == 0) begin
        c = $urandom_range(0, 2);
        half_n[c] = $urandom_range(0, 6);
        dur_n[c]  = $urandom_range(0, 30);
      end
      if ($urandom_range(0, 199) == 0) vol_n = $urandom_range(0, 255);
      if ($urandom_range(0, 299) == 0) mute_n = ~mute_n;
      if ($urandom_range(0, 999) == 0) begin
        tick(t, 1'b1); tick(t, 1'b1); tick(t, 1'b0);
      end else tick(t, 1'b0);
    end
    idle(60);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
